// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the shared 4:1 mux arbiter.
// Handshake: req_i[k] is a level request that requester k holds for as long as it wants
// the mux; gnt_o[k]/valid_o stay high from the edge that grants until the edge after
// req_i[k] falls (or a forced release), and sel_o drives the mux select throughout.
interface mux4_rr_arbiter_if;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic [1:0] sel_o;
    logic       valid_o;
    logic       preempt_o;

    modport master (
        input  req_i,
        output gnt_o,
        output sel_o,
        output valid_o,
        output preempt_o
    );

    modport slave (
        output req_i,
        input  gnt_o,
        input  sel_o,
        input  valid_o,
        input  preempt_o
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux; grants are held until the owner releases.
// Define ARB_HOLD_LIMIT_EN to force release after HOLD_MAX grant cycles when others wait.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mux4_rr_arbiter_if.master bus,
    output logic              state_dbg_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;
    logic       valid_q;
    logic [1:0] ptr;
    logic [1:0] winner;
    logic       owner_req;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("HOLD_MAX must lie in 1..255");
    end

    // First requester at or after the pointer, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign winner    = rr_pick(bus.req_i, ptr);
    assign owner_req = bus.req_i[sel_q];

`ifdef ARB_HOLD_LIMIT_EN
    localparam int            CW       = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

    logic [CW-1:0] hold_cnt;
    logic          preempt_q;
    logic          others_req;

    assign others_req = (bus.req_i & ~gnt_q) != 4'b0000;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            ptr     <= 2'd0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt  <= '0;
            preempt_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
            preempt_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.req_i != 4'b0000) begin
                        state   <= GRANT;
                        gnt_q   <= 4'b0001 << winner;
                        sel_q   <= winner;
                        valid_q <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                        hold_cnt <= CW'(1);
`endif
                    end
                end
                GRANT: begin
                    // sel_q keeps the old owner after release so the mux output stays put.
                    if (!owner_req) begin
                        state   <= IDLE;
                        gnt_q   <= 4'b0000;
                        valid_q <= 1'b0;
                        ptr     <= sel_q + 2'd1;
                    end
`ifdef ARB_HOLD_LIMIT_EN
                    else if (hold_cnt == HOLD_LIM && others_req) begin
                        state     <= IDLE;
                        gnt_q     <= 4'b0000;
                        valid_q   <= 1'b0;
                        ptr       <= sel_q + 2'd1;
                        preempt_q <= 1'b1;
                    end else if (hold_cnt != HOLD_LIM) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
`endif
                end
                default: begin
                    state   <= IDLE;
                    gnt_q   <= 4'b0000;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_o   = gnt_q;
    assign bus.sel_o   = sel_q;
    assign bus.valid_o = valid_q;
`ifdef ARB_HOLD_LIMIT_EN
    assign bus.preempt_o = preempt_q;
`else
    assign bus.preempt_o = 1'b0;
`endif
    assign state_dbg_o = state;

    // Ownership invariants of the grant bundle.
    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(gnt_q));
    a_valid_iff_gnt : assert property (@(posedge clk_i) disable iff (rst_i)
        valid_q == (gnt_q != 4'b0000));
    a_sel_matches : assert property (@(posedge clk_i) disable iff (rst_i)
        !valid_q || gnt_q[sel_q]);

endmodule
